command_timers_dispatch: RTL and testbench

- Initiator side of the timer command protocol. Accepts IO load/store commands from the core's IO port and decodes them into Set/Clear/Check/Wait commands for TIMERCOUNT timer cells.
- Owns the shared free-running 32-bit counter that drives every cell.
- Arbitrates the cells' response streams into one register-writeback stream.

---
 rtl/command_timers_dispatch.sv | 231 +++++++++++++++++++++++
 tb/tb_command_timers_dispatch.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_timers_dispatch.sv
// rtl/command_timers_dispatch.sv - timer command initiator: IO decode, shared counter, response arbiter
module command_timers_dispatch #(
  parameter int DATABITWIDTH = 16,
  parameter int TIMERCOUNT   = 4,
  parameter int IDXBITS      = $clog2(TIMERCOUNT)
) (
  input  logic                           clk,
  input  logic                           clk_en,
  input  logic                           sync_rst,
  input  logic                           CommandInACK,
  output logic                           CommandInREQ,
  input  logic [DATABITWIDTH-1:0]        CommandAddressIn,
  input  logic [3:0]                     MinorOpcodeIn,
  input  logic [3:0]                     RegisterDestIn,
  input  logic [DATABITWIDTH-1:0]        StoreDataIn,
  input  logic                           IsStoreIn,
  output logic [31:0]                    CounterOut,
  output logic [TIMERCOUNT-1:0]          TimerInACK,
  input  logic [TIMERCOUNT-1:0]          TimerInREQ,
  output logic [31:0]                    ComparisonValueOut,
  output logic [3:0]                     MinorOpcodeOut,
  output logic [DATABITWIDTH-1:0]        CommandAddressOut,
  output logic [3:0]                     RegisterDestOut,
  output logic                           TimerSet,
  output logic                           TimerClear,
  output logic                           TimerCheck,
  output logic                           TimerWait,
  input  logic [TIMERCOUNT-1:0]          TimerOutACK,
  output logic [TIMERCOUNT-1:0]          TimerOutREQ,
  input  logic [TIMERCOUNT*DATABITWIDTH-1:0] TimerDataIn,
  input  logic [TIMERCOUNT*4-1:0]        TimerRegDestIn,
  output logic                           WritebackACK,
  input  logic                           WritebackREQ,
  output logic [DATABITWIDTH-1:0]        WritebackData,
  output logic [3:0]                     WritebackRegDest
);

  localparam int PTRBITS = $clog2(TIMERCOUNT + 1);
  localparam int NSLOT = 1 << PTRBITS;
  localparam logic [PTRBITS:0] NREQ = (PTRBITS + 1)'(TIMERCOUNT + 1);
  localparam logic [PTRBITS-1:0] ZEROSLOT = PTRBITS'(TIMERCOUNT);

  typedef enum logic {IDLE, ISSUE} stateT;

  stateT state;
  logic [31:0] counterReg;
  logic [DATABITWIDTH-1:0] lowStage;
  logic [IDXBITS-1:0] idxReg;
  logic zeroPending;
  logic [TIMERCOUNT-1:0] timerInAckReg;
  logic setReg, clearReg, checkReg, waitReg;
  logic [31:0] cmpReg;
  logic [DATABITWIDTH-1:0] addrReg;
  logic [3:0] opReg, destReg;

  logic [IDXBITS-1:0] idx;
  logic [1:0] off;
  logic idxValid, cmdValid, cmdInReq;
  logic [TIMERCOUNT-1:0] idxOneHot;
  logic [2*DATABITWIDTH-1:0] setWide;
  logic [31:0] setValue;

  assign idx       = CommandAddressIn[3 +: IDXBITS];
  assign off       = CommandAddressIn[2:1];
  assign idxValid  = (32'(idx) < 32'(TIMERCOUNT));
  assign cmdValid  = idxValid & (off != 2'd3);
  assign cmdInReq  = (state == IDLE) & ~zeroPending;
  assign idxOneHot = TIMERCOUNT'(1) << idx;
  assign setWide   = {StoreDataIn, lowStage};

  // Set value is always 32 bits: truncate wide ports, zero-fill narrow ones
  generate
    if (2 * DATABITWIDTH >= 32) begin : gSetTrunc
      assign setValue = setWide[31:0];
    end else begin : gSetPad
      assign setValue = {{(32 - 2 * DATABITWIDTH){1'b0}}, setWide};
    end
  endgenerate

  assign CommandInREQ       = cmdInReq;
  assign CounterOut         = counterReg;
  assign TimerInACK         = timerInAckReg;
  assign ComparisonValueOut = cmpReg;
  assign MinorOpcodeOut     = opReg;
  assign CommandAddressOut  = addrReg;
  assign RegisterDestOut    = destReg;
  assign TimerSet           = setReg;
  assign TimerClear         = clearReg;
  assign TimerCheck         = checkReg;
  assign TimerWait          = waitReg;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      counterReg <= '0;
    end else if (clk_en) begin
      counterReg <= counterReg + 32'd1;
    end
  end

  // Arbiter signals
  logic [NSLOT-1:0] req;
  logic [PTRBITS-1:0] ptr, winner;
  logic [PTRBITS:0] slotSum;
  logic winnerValid, canLoad, grant, zeroGrant;
  logic wbAckReg;
  logic [DATABITWIDTH-1:0] wbDataReg, winData;
  logic [3:0] wbDestReg, winDest;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state         <= IDLE;
      lowStage      <= '0;
      idxReg        <= '0;
      zeroPending   <= 1'b0;
      timerInAckReg <= '0;
      setReg        <= 1'b0;
      clearReg      <= 1'b0;
      checkReg      <= 1'b0;
      waitReg       <= 1'b0;
      cmpReg        <= '0;
      addrReg       <= '0;
      opReg         <= '0;
      destReg       <= '0;
    end else if (clk_en) begin
      if (zeroGrant) zeroPending <= 1'b0;
      case (state)
        IDLE: begin
          if (CommandInACK && cmdInReq) begin
            addrReg <= CommandAddressIn;
            opReg   <= MinorOpcodeIn;
            destReg <= RegisterDestIn;
            idxReg  <= idx;
            if (IsStoreIn) begin
              if (cmdValid && off == 2'd0) begin
                lowStage <= StoreDataIn;
              end else if (cmdValid && off == 2'd1) begin
                cmpReg        <= setValue;
                setReg        <= 1'b1;
                timerInAckReg <= idxOneHot;
                state         <= ISSUE;
              end else if (cmdValid && off == 2'd2) begin
                clearReg      <= 1'b1;
                timerInAckReg <= idxOneHot;
                state         <= ISSUE;
              end
            end else if (!cmdValid) begin
              zeroPending <= 1'b1;
            end else begin
              waitReg       <= (off == 2'd2);
              checkReg      <= (off != 2'd2);
              timerInAckReg <= idxOneHot;
              state         <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (TimerInREQ[idxReg]) begin
            timerInAckReg <= '0;
            setReg        <= 1'b0;
            clearReg      <= 1'b0;
            checkReg      <= 1'b0;
            waitReg       <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req = '0;
    req[TIMERCOUNT-1:0] = TimerOutACK;
    req[TIMERCOUNT] = zeroPending;
  end

  // Round-robin search starting at the slot after the previous winner
  always_comb begin
    winner = '0;
    winnerValid = 1'b0;
    slotSum = '0;
    for (int k = 0; k <= TIMERCOUNT; k++) begin
      slotSum = {1'b0, ptr} + (PTRBITS + 1)'(k);
      if (slotSum >= NREQ) slotSum = slotSum - NREQ;
      if (!winnerValid && req[slotSum[PTRBITS-1:0]]) begin
        winnerValid = 1'b1;
        winner = slotSum[PTRBITS-1:0];
      end
    end
  end

  assign canLoad   = ~wbAckReg | WritebackREQ;
  assign grant     = winnerValid & canLoad;
  assign zeroGrant = grant & (winner == ZEROSLOT);

  always_comb begin
    TimerOutREQ = '0;
    winData = '0;
    winDest = destReg;
    for (int i = 0; i < TIMERCOUNT; i++) begin
      if (winner == PTRBITS'(i)) begin
        TimerOutREQ[i] = grant;
        winData = TimerDataIn[i*DATABITWIDTH +: DATABITWIDTH];
        winDest = TimerRegDestIn[i*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      wbAckReg  <= 1'b0;
      wbDataReg <= '0;
      wbDestReg <= '0;
      ptr       <= '0;
    end else if (clk_en) begin
      if (grant) begin
        wbAckReg  <= 1'b1;
        wbDataReg <= winData;
        wbDestReg <= winDest;
        ptr       <= (winner == ZEROSLOT) ? '0 : winner + PTRBITS'(1);
      end else if (WritebackREQ) begin
        wbAckReg <= 1'b0;
      end
    end
  end

  assign WritebackACK     = wbAckReg;
  assign WritebackData    = wbDataReg;
  assign WritebackRegDest = wbDestReg;

endmodule

// File: tb/tb_command_timers_dispatch.sv
// tb/tb_command_timers_dispatch.sv - randomized self-checking bench for command_timers_dispatch
module tb_command_timers_dispatch;
  localparam int DW = 16;
  localparam int TC = 4;

  logic clk = 1'b0;
  logic clk_en, sync_rst;
  logic CommandInACK, CommandInREQ;
  logic [DW-1:0] CommandAddressIn, StoreDataIn;
  logic [3:0] MinorOpcodeIn, RegisterDestIn;
  logic IsStoreIn;
  logic [31:0] CounterOut, ComparisonValueOut;
  logic [TC-1:0] TimerInACK, TimerInREQ, TimerOutACK, TimerOutREQ;
  logic [3:0] MinorOpcodeOut, RegisterDestOut;
  logic [DW-1:0] CommandAddressOut;
  logic TimerSet, TimerClear, TimerCheck, TimerWait;
  logic [TC*DW-1:0] TimerDataIn;
  logic [TC*4-1:0] TimerRegDestIn;
  logic WritebackACK, WritebackREQ;
  logic [DW-1:0] WritebackData;
  logic [3:0] WritebackRegDest;

  command_timers_dispatch #(.DATABITWIDTH(DW), .TIMERCOUNT(TC)) dut (
    .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst),
    .CommandInACK(CommandInACK), .CommandInREQ(CommandInREQ),
    .CommandAddressIn(CommandAddressIn), .MinorOpcodeIn(MinorOpcodeIn),
    .RegisterDestIn(RegisterDestIn), .StoreDataIn(StoreDataIn), .IsStoreIn(IsStoreIn),
    .CounterOut(CounterOut), .TimerInACK(TimerInACK), .TimerInREQ(TimerInREQ),
    .ComparisonValueOut(ComparisonValueOut), .MinorOpcodeOut(MinorOpcodeOut),
    .CommandAddressOut(CommandAddressOut), .RegisterDestOut(RegisterDestOut),
    .TimerSet(TimerSet), .TimerClear(TimerClear), .TimerCheck(TimerCheck), .TimerWait(TimerWait),
    .TimerOutACK(TimerOutACK), .TimerOutREQ(TimerOutREQ),
    .TimerDataIn(TimerDataIn), .TimerRegDestIn(TimerRegDestIn),
    .WritebackACK(WritebackACK), .WritebackREQ(WritebackREQ),
    .WritebackData(WritebackData), .WritebackRegDest(WritebackRegDest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: pending cell responses, writeback register, rotation slot, staging word
  int mPtr;
  bit mAck;
  logic [DW-1:0] mData;
  logic [3:0] mDest;
  bit pend[TC];
  logic [DW-1:0] pData[TC];
  logic [3:0] pDest[TC];
  bit mZero;
  logic [3:0] mZeroDest;
  logic [DW-1:0] mLow;

  task automatic drive_cells();
    for (int i = 0; i < TC; i++) begin
      TimerOutACK[i] = pend[i];
      TimerDataIn[i*DW +: DW] = pData[i];
      TimerRegDestIn[i*4 +: 4] = pDest[i];
    end
  endtask

  task automatic step_arb(input bit wbReq);
    int w;
    bit canLoad;
    logic [TC-1:0] expReq;
    drive_cells();
    WritebackREQ = wbReq;
    #1;
    canLoad = !mAck || wbReq;
    w = -1;
    for (int k = 0; k <= TC; k++) begin
      int s;
      s = (mPtr + k) % (TC + 1);
      if (w < 0 && ((s < TC && pend[s]) || (s == TC && mZero))) w = s;
    end
    expReq = '0;
    if (canLoad && w >= 0 && w < TC) expReq[w] = 1'b1;
    checks++;
    if (TimerOutREQ !== expReq)
      begin failures++; $display("FAIL arb_outreq got=%b want=%b", TimerOutREQ, expReq); end
    if (canLoad && w >= 0) begin
      mAck = 1'b1;
      if (w == TC) begin mData = '0; mDest = mZeroDest; mZero = 1'b0; end
      else begin mData = pData[w]; mDest = pDest[w]; pend[w] = 1'b0; end
      mPtr = (w + 1) % (TC + 1);
    end else if (wbReq) begin
      mAck = 1'b0;
    end
    @(posedge clk);
    #1 drive_cells();
    @(negedge clk);
    checks++;
    if (WritebackACK !== mAck)
      begin failures++; $display("FAIL wb_ack got=%b want=%b", WritebackACK, mAck); end
    if (mAck) begin
      checks++;
      if ({WritebackData, WritebackRegDest} !== {mData, mDest})
        begin failures++; $display("FAIL wb_data got=%h/%0d want=%h/%0d", WritebackData, WritebackRegDest, mData, mDest); end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((mAck || mZero || pend[0] || pend[1] || pend[2] || pend[3]) && n < 30) begin
      step_arb(1'b1);
      n++;
    end
    WritebackREQ = 1'b1;
  endtask

  task automatic send_cmd(input logic [DW-1:0] addr, input logic [3:0] op, input logic [3:0] dest,
                          input logic [DW-1:0] data, input bit isStore);
    int n = 0;
    while (!CommandInREQ && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (CommandInREQ !== 1'b1)
      begin failures++; $display("FAIL cmd_req_timeout got=%b want=1", CommandInREQ); end
    CommandAddressIn = addr; MinorOpcodeIn = op; RegisterDestIn = dest;
    StoreDataIn = data; IsStoreIn = isStore; CommandInACK = 1'b1;
    @(posedge clk);
    #1 CommandInACK = 1'b0;
    @(negedge clk);
  endtask

  // Sends one command, predicts its decode from the address rules, holds the cell off for 'hold' cycles
  task automatic issue_cmd(input logic [DW-1:0] addr, input logic [3:0] op, input logic [3:0] dest,
                           input logic [DW-1:0] data, input bit isStore, input int hold);
    int idx, off, kind;
    logic [TC-1:0] oneHot;
    logic [3:0] strobes;
    logic [31:0] expCmp;
    idx = int'(addr[4:3]);
    off = int'(addr[2:1]);
    oneHot = '0;
    oneHot[idx] = 1'b1;
    expCmp = {data, mLow};
    kind = 0;
    if (isStore) begin
      if (off == 0) mLow = data;
      else if (off == 1) kind = 1;
      else if (off == 2) kind = 2;
    end else begin
      if (off <= 1) kind = 3;
      else if (off == 2) kind = 4;
      else kind = 5;
    end
    send_cmd(addr, op, dest, data, isStore);
    if (kind >= 1 && kind <= 4) begin
      strobes = 4'b1000 >> (kind - 1);
      for (int c = 0; c <= hold; c++) begin
        TimerInREQ = 4'($urandom) & ~oneHot;
        if (c == hold) TimerInREQ = TimerInREQ | oneHot;
        checks++;
        if ({TimerInACK, TimerSet, TimerClear, TimerCheck, TimerWait, CommandInREQ} !== {oneHot, strobes, 1'b0})
          begin failures++; $display("FAIL issue_hold ack=%b strobes=%b req=%b want ack=%b strobes=%b req=0",
                TimerInACK, {TimerSet, TimerClear, TimerCheck, TimerWait}, CommandInREQ, oneHot, strobes); end
        checks++;
        if ({CommandAddressOut, MinorOpcodeOut, RegisterDestOut} !== {addr, op, dest})
          begin failures++; $display("FAIL issue_buffers got=%h/%h/%h want=%h/%h/%h",
                CommandAddressOut, MinorOpcodeOut, RegisterDestOut, addr, op, dest); end
        if (kind == 1) begin
          checks++;
          if (ComparisonValueOut !== expCmp)
            begin failures++; $display("FAIL set_value got=%h want=%h", ComparisonValueOut, expCmp); end
        end
        @(posedge clk);
        @(negedge clk);
      end
      TimerInREQ = '0;
      checks++;
      if ({TimerInACK, CommandInREQ} !== {{TC{1'b0}}, 1'b1})
        begin failures++; $display("FAIL issue_done ack=%b req=%b want ack=0 req=1", TimerInACK, CommandInREQ); end
    end else if (kind == 5) begin
      mZero = 1'b1;
      mZeroDest = dest;
      checks++;
      if ({TimerInACK, CommandInREQ} !== {{TC{1'b0}}, 1'b0})
        begin failures++; $display("FAIL zero_pending ack=%b req=%b want ack=0 req=0", TimerInACK, CommandInREQ); end
      drain();
    end else begin
      checks++;
      if ({TimerInACK, CommandInREQ} !== {{TC{1'b0}}, 1'b1})
        begin failures++; $display("FAIL no_issue ack=%b req=%b want ack=0 req=1", TimerInACK, CommandInREQ); end
    end
  endtask

  task automatic test_reset();
    clk_en = 1'b1; sync_rst = 1'b1;
    CommandInACK = 1'b0; CommandAddressIn = '0; MinorOpcodeIn = '0; RegisterDestIn = '0;
    StoreDataIn = '0; IsStoreIn = 1'b0; TimerInREQ = '0; WritebackREQ = 1'b1;
    mPtr = 0; mAck = 1'b0; mData = '0; mDest = '0; mZero = 1'b0; mZeroDest = '0; mLow = '0;
    for (int i = 0; i < TC; i++) begin pend[i] = 1'b0; pData[i] = '0; pDest[i] = '0; end
    drive_cells();
    repeat (3) @(posedge clk);
    @(negedge clk);
    sync_rst = 1'b0; clk_en = 1'b0;
    #1;
    checks++;
    if (CounterOut !== 32'd0)
      begin failures++; $display("FAIL reset_counter got=%h want=0", CounterOut); end
    checks++;
    if ({TimerInACK, TimerOutREQ, WritebackACK, CommandInREQ} !== {{TC{1'b0}}, {TC{1'b0}}, 1'b0, 1'b1})
      begin failures++; $display("FAIL reset_handshake inack=%b outreq=%b wback=%b cmdreq=%b want 0/0/0/1",
            TimerInACK, TimerOutREQ, WritebackACK, CommandInREQ); end
    checks++;
    if ({TimerSet, TimerClear, TimerCheck, TimerWait} !== 4'b0000)
      begin failures++; $display("FAIL reset_strobes got=%b want=0000", {TimerSet, TimerClear, TimerCheck, TimerWait}); end
  endtask

  task automatic test_counter();
    repeat (3) @(negedge clk);
    checks++;
    if (CounterOut !== 32'd0)
      begin failures++; $display("FAIL counter_hold got=%h want=0", CounterOut); end
    clk_en = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (CounterOut !== 32'd5)
      begin failures++; $display("FAIL counter_five got=%h want=5", CounterOut); end
    clk_en = 1'b0;
    force dut.counterReg = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.counterReg;
    #1;
    checks++;
    if (CounterOut !== 32'hFFFF_FFFF)
      begin failures++; $display("FAIL counter_preload got=%h want=ffffffff", CounterOut); end
    clk_en = 1'b1;
    @(negedge clk);
    checks++;
    if (CounterOut !== 32'd0)
      begin failures++; $display("FAIL counter_wrap got=%h want=0", CounterOut); end
    @(negedge clk);
    checks++;
    if (CounterOut !== 32'd1)
      begin failures++; $display("FAIL counter_after_wrap got=%h want=1", CounterOut); end
  endtask

  task automatic test_set();
    issue_cmd(16'h0008, 4'h2, 4'h0, 16'h5678, 1'b1, 0);
    issue_cmd(16'h000A, 4'h2, 4'h0, 16'h1234, 1'b1, 3);
  endtask

  task automatic test_wait();
    issue_cmd(16'h0014, 4'h1, 4'h7, 16'h0000, 1'b0, 10);
  endtask

  task automatic test_clk_en();
    send_cmd(16'h001C, 4'h0, 4'h0, 16'h0000, 1'b1);
    clk_en = 1'b0;
    TimerInREQ = '1;
    repeat (2) @(negedge clk);
    checks++;
    if ({TimerInACK, TimerClear} !== {4'b1000, 1'b1})
      begin failures++; $display("FAIL clk_en_hold ack=%b clear=%b want 1000/1", TimerInACK, TimerClear); end
    clk_en = 1'b1;
    @(negedge clk);
    TimerInREQ = '0;
    checks++;
    if ({TimerInACK, CommandInREQ} !== {4'b0000, 1'b1})
      begin failures++; $display("FAIL clk_en_release ack=%b req=%b want 0000/1", TimerInACK, CommandInREQ); end
  endtask

  task automatic test_arbiter();
    pend[0] = 1'b1; pData[0] = 16'h0011; pDest[0] = 4'd1;
    pend[3] = 1'b1; pData[3] = 16'h0033; pDest[3] = 4'd3;
    step_arb(1'b1);
    checks++;
    if (WritebackData !== 16'h0011)
      begin failures++; $display("FAIL rr_first got=%h want=0011", WritebackData); end
    pend[0] = 1'b1; pData[0] = 16'h0022; pDest[0] = 4'd2;
    step_arb(1'b1);
    checks++;
    if (WritebackData !== 16'h0033)
      begin failures++; $display("FAIL rr_second got=%h want=0033", WritebackData); end
    step_arb(1'b1);
    drain();
  endtask

  task automatic test_backpressure();
    pend[1] = 1'b1; pData[1] = 16'hAAAA; pDest[1] = 4'd5;
    pend[2] = 1'b1; pData[2] = 16'hBBBB; pDest[2] = 4'd6;
    step_arb(1'b1);
    repeat (3) step_arb(1'b0);
    step_arb(1'b1);
    drain();
  endtask

  task automatic test_invalid();
    issue_cmd(16'h0026, 4'h3, 4'h9, 16'h0000, 1'b0, 0);
    issue_cmd(16'h0040, 4'h1, 4'h0, 16'hBEEF, 1'b1, 0);
    issue_cmd(16'h0006, 4'h1, 4'h0, 16'hCAFE, 1'b1, 0);
  endtask

  task automatic test_random_commands();
    for (int n = 0; n < 40; n++) begin
      logic [DW-1:0] addr;
      addr = 16'($urandom);
      issue_cmd(addr, 4'($urandom), 4'($urandom), 16'($urandom), bit'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_random_arbiter();
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < TC; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1; pData[i] = 16'($urandom); pDest[i] = 4'($urandom);
        end
      end
      step_arb(bit'($urandom_range(0, 3) != 0));
    end
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog elapsed got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_counter();
    test_set();
    test_wait();
    test_clk_en();
    test_arbiter();
    test_backpressure();
    test_invalid();
    test_random_commands();
    test_random_arbiter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
